// File: rtl/ahb_spi_tx_pkg.sv
// Shared constants for the AHB-Lite SPI transmitter: register offsets, field
// positions, reset values, AHB transfer encodings and the shifter state type.
package ahb_spi_tx_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int CTRL_LSB_FIRST_BIT = 0;
  localparam int CTRL_CLKDIV_LSB    = 8;
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_OVERRUN_BIT = 1;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0100;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/ahb_spi_tx_shifter.sv
// SPI mode-0 frame generator: divider, bit counter and shift register driving
// SCLK/SS/MOSI for one 8-bit frame per start pulse.
module spi_tx_shifter
  import ahb_spi_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       lsb_first_i,
  input  logic [7:0] clkdiv_i,
  output logic       busy_o,
  output logic       sclk_o,
  output logic       ss_o,
  output logic       mosi_o
);
  // state    | meaning
  // ST_IDLE  | SS high, SCLK low, MOSI 0, waiting for start_i
  // ST_SHIFT | frame in progress, toggling SCLK every CLKDIV+1 cycles

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] hdiv_q, hdiv_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       lsb_q, lsb_d;
  logic       sclk_q, sclk_d;
  logic       ss_q, ss_d;
  logic       mosi_q, mosi_d;
  logic [7:0] sh_next;

  assign sh_next = lsb_q ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      hdiv_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hdiv_q  <= hdiv_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      lsb_q   <= lsb_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hdiv_d  = hdiv_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    lsb_d   = lsb_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SHIFT;
          shreg_d = data_i;
          lsb_d   = lsb_first_i;
          hdiv_d  = clkdiv_i;
          div_d   = clkdiv_i;
          bit_d   = '0;
          sclk_d  = 1'b0;
          ss_d    = 1'b0;
          mosi_d  = lsb_first_i ? data_i[0] : data_i[7];
        end
      end
      ST_SHIFT: begin
        if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = hdiv_q;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // Falling edge: either the frame ends or MOSI moves to the next bit.
            if (bit_q == 3'd7) begin
              state_d = ST_IDLE;
              ss_d    = 1'b1;
              mosi_d  = 1'b0;
            end else begin
              bit_d   = bit_q + 3'd1;
              shreg_d = sh_next;
              mosi_d  = lsb_q ? sh_next[0] : sh_next[7];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q == ST_SHIFT);
  assign sclk_o = sclk_q;
  assign ss_o   = ss_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/ahb_spi_tx.sv
// AHB-Lite register block (TXDATA/CTRL/STATUS) in front of a transmit-only
// SPI mode-0 master.
module ahb_spi_tx
  import ahb_spi_tx_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic [3:0]  HADDR,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic        HREADY_RESP,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        SCLK,
  output logic        SS,
  output logic        MOSI
);

  logic       dph_valid_q, dph_write_q;
  logic [1:0] dph_addr_q;
  logic [3:0] dph_off;
  logic [7:0] txdata_q, txdata_d;
  logic [7:0] clkdiv_q, clkdiv_d;
  logic       lsb_first_q, lsb_first_d;
  logic       overrun_q, overrun_d;
  logic       addr_ok, wr_tx, wr_ctrl, rd_status, busy, start;
  logic       unused_bits;

  assign unused_bits = ^{HWDATA[31:16], HADDR[1:0]};

  assign addr_ok = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign dph_off = {dph_addr_q, 2'b00};

  assign wr_tx     = dph_valid_q && dph_write_q && (dph_off == OFF_TXDATA);
  assign wr_ctrl   = dph_valid_q && dph_write_q && (dph_off == OFF_CTRL);
  assign rd_status = dph_valid_q && !dph_write_q && (dph_off == OFF_STATUS);
  assign start     = wr_tx && !busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dph_valid_q <= 1'b0;
      dph_write_q <= 1'b0;
      dph_addr_q  <= '0;
      txdata_q    <= '0;
      clkdiv_q    <= CTRL_RESET[CTRL_CLKDIV_LSB +: 8];
      lsb_first_q <= CTRL_RESET[CTRL_LSB_FIRST_BIT];
      overrun_q   <= 1'b0;
    end else begin
      dph_valid_q <= addr_ok;
      if (addr_ok) begin
        dph_write_q <= HWRITE;
        dph_addr_q  <= HADDR[3:2];
      end
      txdata_q    <= txdata_d;
      clkdiv_q    <= clkdiv_d;
      lsb_first_q <= lsb_first_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    txdata_d    = txdata_q;
    clkdiv_d    = clkdiv_q;
    lsb_first_d = lsb_first_q;
    overrun_d   = overrun_q;
    if (start) txdata_d = HWDATA[7:0];
    if (wr_ctrl) begin
      clkdiv_d    = HWDATA[CTRL_CLKDIV_LSB +: 8];
      lsb_first_d = HWDATA[CTRL_LSB_FIRST_BIT];
    end
    if (rd_status) overrun_d = 1'b0;
    // A dropped write in the same cycle as a STATUS read keeps OVERRUN set.
    if (wr_tx && busy) overrun_d = 1'b1;
  end

  always_comb begin
    HRDATA = '0;
    if (dph_valid_q && !dph_write_q) begin
      case (dph_off)
        OFF_TXDATA: HRDATA[7:0] = txdata_q;
        OFF_CTRL: begin
          HRDATA[CTRL_LSB_FIRST_BIT]     = lsb_first_q;
          HRDATA[CTRL_CLKDIV_LSB +: 8]   = clkdiv_q;
        end
        OFF_STATUS: begin
          HRDATA[STATUS_BUSY_BIT]    = busy;
          HRDATA[STATUS_OVERRUN_BIT] = overrun_q;
        end
        default: HRDATA = '0;
      endcase
    end
  end

  assign HREADY_RESP = 1'b1;

  spi_tx_shifter u_shifter (
    .clk         (CLK),
    .rst_n       (RST_N),
    .start_i     (start),
    .data_i      (HWDATA[7:0]),
    .lsb_first_i (lsb_first_q),
    .clkdiv_i    (clkdiv_q),
    .busy_o      (busy),
    .sclk_o      (SCLK),
    .ss_o        (SS),
    .mosi_o      (MOSI)
  );

endmodule

// File: tb/tb_ahb_spi_tx.sv
// Self-checking bench for ahb_spi_tx: directed cases plus random bus traffic
// checked against a cycle-count reference model and an SPI frame monitor.
module tb_ahb_spi_tx;

  localparam logic [3:0] A_TX   = 4'h0;
  localparam logic [3:0] A_CTRL = 4'h4;
  localparam logic [3:0] A_STAT = 4'h8;
  localparam logic [3:0] A_RSVD = 4'hC;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        HSEL = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [3:0]  HADDR = 4'h0;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic        HREADY_RESP;
  logic [31:0] HWDATA = 32'h0;
  logic [31:0] HRDATA;
  logic        SCLK, SS, MOSI;

  ahb_spi_tx dut (
    .CLK(CLK), .RST_N(RST_N), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HREADY(HREADY), .HREADY_RESP(HREADY_RESP),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .SCLK(SCLK), .SS(SS), .MOSI(MOSI)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Reference model: register contents plus the cycle at which the current frame ends.
  typedef struct {
    logic [7:0] d;
    bit         lsb;
    int         h;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] m_tx;
  bit         m_lsb;
  logic [7:0] m_div;
  bit         m_ovr;
  int         m_end;

  task automatic model_reset();
    m_tx = 8'h00; m_lsb = 1'b0; m_div = 8'd1; m_ovr = 1'b0; m_end = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {24'h0, m_tx};
      2'd1:    return {16'h0, m_div, 7'h0, m_lsb};
      2'd2:    return {30'h0, m_ovr, (cyc < m_end)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic addr_phase(input logic [3:0] a, input logic wr);
    @(posedge CLK); #1;
    HSEL   = 1'b1;
    HTRANS = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    HADDR  = {a[3:2], 2'($urandom_range(0, 3))};
    HWRITE = wr;
    @(posedge CLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  // Returns inside the data phase; the next bus task's first edge completes it.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    frame_t f;
    addr_phase(a, 1'b1);
    HWDATA = d;
    case (a[3:2])
      2'd0: begin
        if (cyc >= m_end) begin
          m_tx  = d[7:0];
          f.d   = d[7:0];
          f.lsb = m_lsb;
          f.h   = int'(m_div) + 1;
          exp_q.push_back(f);
          m_end = cyc + 1 + 16 * f.h;
        end else begin
          m_ovr = 1'b1;
        end
      end
      2'd1: begin
        m_lsb = d[0];
        m_div = d[15:8];
      end
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [3:0] a, input string tag, output logic [31:0] r);
    logic [31:0] e;
    addr_phase(a, 1'b0);
    e = model_read(a);
    #3;
    r = HRDATA;
    check(tag, HRDATA, e);
    check("hready_resp", 32'(HREADY_RESP), 32'h1);
    if (a[3:2] == 2'd2) m_ovr = 1'b0;
  endtask

  // Transfers the slave must ignore: deselected, IDLE/BUSY, or HREADY low.
  task automatic bus_ignored();
    int kind;
    kind = $urandom_range(0, 2);
    @(posedge CLK); #1;
    HSEL   = (kind != 0);
    HTRANS = (kind == 1) ? 2'($urandom_range(0, 1)) : 2'b10;
    HREADY = (kind != 2);
    HADDR  = 4'($urandom_range(0, 15));
    HWRITE = 1'b1;
    @(posedge CLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
    HWDATA = $urandom;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (cyc < m_end + 1 && g < 20000) begin
      @(posedge CLK);
      g++;
    end
    if (g >= 20000) check("wait_idle_timeout", 32'h1, 32'h0);
    repeat (2) @(posedge CLK);
  endtask

  // SPI frame monitor, sampling mid-cycle on the falling CLK edge.
  int         mon_low, mon_hi, mon_lead, mon_nb;
  logic [7:0] mon_rx;
  bit         mon_rise;
  bit         prev_ss = 1'b1;
  bit         prev_sclk = 1'b0;

  task automatic mon_clear();
    mon_low = 0; mon_hi = 0; mon_lead = 0; mon_nb = 0; mon_rx = 8'h00; mon_rise = 1'b0;
  endtask

  task automatic frame_done();
    frame_t     f;
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'h1, 32'h0);
    end else begin
      f = exp_q.pop_front();
      e = 8'h00;
      for (int i = 0; i < 8; i++) e = {e[6:0], (f.lsb ? f.d[i] : f.d[7-i])};
      check("frame_bits", 32'(mon_rx), 32'(e));
      check("frame_nbits", 32'(mon_nb), 32'd8);
      check("ss_low_cycles", 32'(mon_low), 32'(16 * f.h));
      check("sclk_high_cycles", 32'(mon_hi), 32'(8 * f.h));
      check("first_rise_delay", 32'(mon_lead), 32'(f.h));
    end
    check("idle_mosi", 32'(MOSI), 32'h0);
    check("idle_sclk", 32'(SCLK), 32'h0);
    mon_clear();
  endtask

  initial begin
    mon_clear();
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        mon_clear();
        prev_ss = 1'b1;
        prev_sclk = 1'b0;
      end else begin
        if (!SS) begin
          mon_low++;
          if (SCLK) mon_hi++;
          if (SCLK && !prev_sclk) begin
            mon_rx = {mon_rx[6:0], MOSI};
            mon_nb++;
            mon_rise = 1'b1;
          end else if (!mon_rise) begin
            mon_lead++;
          end
        end else if (!prev_ss) begin
          frame_done();
        end
        prev_ss = SS;
        prev_sclk = SCLK;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic read_all(input string tag);
    logic [31:0] r;
    bus_read(A_TX, {tag, "_txdata"}, r);
    bus_read(A_CTRL, {tag, "_ctrl"}, r);
    bus_read(A_STAT, {tag, "_status"}, r);
    bus_read(A_RSVD, {tag, "_rsvd"}, r);
  endtask

  initial begin
    logic [31:0] r, d;
    int polls;
    model_reset();
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    check("rst_ss", 32'(SS), 32'h1);
    check("rst_sclk", 32'(SCLK), 32'h0);
    check("rst_mosi", 32'(MOSI), 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hready_resp", 32'(HREADY_RESP), 32'h1);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    read_all("reset");

    // MSB first, H = 2
    bus_write(A_CTRL, 32'h0000_0100);
    bus_write(A_TX, 32'h0000_00A5);
    bus_read(A_STAT, "a5_busy", r);
    wait_idle();
    bus_read(A_STAT, "a5_done", r);

    // LSB first, H = 4
    bus_write(A_CTRL, 32'h0000_0301);
    bus_write(A_TX, 32'h0000_0001);
    wait_idle();
    read_all("lsb01");

    // LSB first, CLKDIV = 0 gives H = 1
    bus_write(A_CTRL, 32'hFFFF_0001);
    bus_write(A_TX, 32'h0000_0096);
    wait_idle();

    // Overrun: second write mid-frame is dropped
    bus_write(A_CTRL, 32'h0000_0100);
    bus_write(A_TX, 32'h0000_00C3);
    repeat (4) @(posedge CLK);
    bus_write(A_TX, 32'h0000_003C);
    bus_read(A_STAT, "ovr_first", r);
    bus_read(A_STAT, "ovr_second", r);
    bus_read(A_TX, "ovr_txdata", r);
    wait_idle();

    // Back-to-back frames, second issued as soon as BUSY reads 0
    bus_write(A_TX, 32'h0000_0081);
    polls = 0;
    do begin
      bus_read(A_STAT, "b2b_poll", r);
      polls++;
    end while (r[0] && polls < 200);
    if (polls >= 200) check("b2b_poll_timeout", 32'h1, 32'h0);
    bus_write(A_TX, 32'h0000_007E);
    wait_idle();

    // Reset in the 4th bit of a frame
    bus_write(A_CTRL, 32'h0000_0101);
    bus_write(A_TX, 32'h0000_005A);
    repeat (14) @(posedge CLK);
    #3;
    check("midrst_ss_before", 32'(SS), 32'h0);
    RST_N = 1'b0;
    #1;
    check("midrst_ss", 32'(SS), 32'h1);
    check("midrst_sclk", 32'(SCLK), 32'h0);
    check("midrst_mosi", 32'(MOSI), 32'h0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    read_all("midrst");

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0, 1: bus_write(A_TX, $urandom);
        2: begin
          d = $urandom;
          d[15:8] = 8'($urandom_range(0, 3));
          bus_write(A_CTRL, d);
        end
        3: bus_read({2'($urandom_range(0, 3)), 2'b00}, "rand_read", r);
        4: begin
          if ($urandom_range(0, 1) == 1) bus_ignored();
          else bus_write({1'b1, 1'($urandom_range(0, 1)), 2'b00}, $urandom);
        end
        default: repeat ($urandom_range(0, 40)) @(posedge CLK);
      endcase
    end
    wait_idle();
    read_all("final");
    check("frames_pending", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
